oscan1_host_encoder: RTL

OSCAN1_HOST_ENCODER -- requirements
Module: oscan1_host_encoder

---
 rtl/oscan1_pkg.sv | 29 ++
 rtl/oscan1_tckc_gen.sv | 53 +++++
 rtl/oscan1_host_encoder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/oscan1_pkg.sv
// Shared OScan1 definitions used by the host-side encoder and the target-side decoder.
// Holds the JScan opcode set, TCKC timing default and frame-length constants.
package oscan1_pkg;

  localparam int HALF_DIV_DEFAULT = 4;
  localparam int OAC_PERIODS      = 8;
  localparam int JSCAN_BITS       = 4;
  localparam int STUFF_ONES       = 5;

  typedef enum logic [3:0] {
    JS_OSCAN_OFF = 4'h0,
    JS_OSCAN_ON  = 4'h1,
    JS_SELECT    = 4'h2,
    JS_DESELECT  = 4'h3,
    JS_SF_SELECT = 4'h4,
    JS_READ_ID   = 4'h5,
    JS_NOOP      = 4'hF
  } jscan_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OAC      = 3'd1,
    ST_JSCAN    = 3'd2,
    ST_SF0_DATA = 3'd3,
    ST_SF0_TDO  = 3'd4,
    ST_STUFF    = 3'd5
  } host_state_e;

endpackage

// File: rtl/oscan1_tckc_gen.sv
// TCKC half-period generator: low half then high half, HALF_DIV clk cycles each.
// rise_o marks the last low cycle, fall_o the last high cycle (period end).
module oscan1_tckc_gen
  import oscan1_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic tckc_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] RELOAD = 8'(HALF_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tckc_q, tckc_d;
  logic       tc;

  assign tc = (cnt_q == 8'd0);

  // Idle preloads the counter so the first low half after start is full length.
  always_comb begin
    cnt_d  = cnt_q;
    tckc_d = tckc_q;
    if (!run_i) begin
      cnt_d  = RELOAD;
      tckc_d = 1'b0;
    end else if (tc) begin
      cnt_d  = RELOAD;
      tckc_d = ~tckc_q;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 8'd0;
      tckc_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tckc_q <= tckc_d;
    end
  end

  assign tckc_o = tckc_q;
  assign rise_o = run_i & tc & ~tckc_q;
  assign fall_o = run_i & tc & tckc_q;

endmodule

// File: rtl/oscan1_host_encoder.sv
// cJTAG OScan1 host encoder: turns OAC+JScan and SF0 scan-bit commands into TCKC/TMSC.
//   state    | meaning
//   IDLE     | tckc low, TMSC released, ready for a command
//   OAC      | 8 periods of TMSC=1 (escape / activation code)
//   JSCAN    | 4 periods carrying the opcode, LSB first
//   SF0_DATA | one period: TMS in low half, TDI in high half
//   STUFF    | one period of TMSC=0 after five consecutive TDI=1 bits
//   SF0_TDO  | one period with TMSC released, target drives TDO
module oscan1_host_encoder
  import oscan1_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_kind,
  input  logic [3:0] cmd_jscan,
  input  logic       cmd_tms,
  input  logic       cmd_tdi,
  output logic       rsp_valid,
  output logic       rsp_tdo,
  output logic       tckc,
  output logic       tmsc_out,
  output logic       tmsc_oen,
  input  logic       tmsc_in,
  output logic       oscan_on,
  output logic       cmd_err
);

  localparam logic [2:0] JS_LAST = 3'(JSCAN_BITS - 1);

  host_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic        tms_q, tms_d, tdi_q, tdi_d;
  logic [2:0]  ones_q, ones_d, ones_inc;
  logic        oscan_q, oscan_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_tdo_q, rsp_tdo_d;
  logic        err_q, err_d;
  logic        hi_q, hi_d;
  logic        rdy_q;
  logic [1:0]  sync_q;
  logic        run, rise, fall, accept;
  logic [1:0]  bit_idx;

  assign run       = (state_q != ST_IDLE);
  assign cmd_ready = rdy_q && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign bit_idx   = 2'(JS_LAST - cnt_q);
  assign ones_inc  = ones_q + 3'd1;

  oscan1_tckc_gen #(.HALF_DIV(HALF_DIV)) u_tckc (
    .clk   (clk),
    .rst_n (rst_n),
    .run_i (run),
    .tckc_o(tckc),
    .rise_o(rise),
    .fall_o(fall)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    ones_d      = ones_q;
    oscan_d     = oscan_q;
    rsp_valid_d = 1'b0;
    rsp_tdo_d   = rsp_tdo_q;
    err_d       = 1'b0;
    hi_d        = hi_q;
    tmsc_out    = 1'b0;
    tmsc_oen    = 1'b0;

    if (!run || fall) hi_d = 1'b0;
    else if (rise)    hi_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!cmd_kind) begin
            state_d = ST_OAC;
            cnt_d   = 3'(OAC_PERIODS - 1);
            op_d    = cmd_jscan;
            ones_d  = 3'd0;
          end else if (oscan_q) begin
            state_d = ST_SF0_DATA;
            tms_d   = cmd_tms;
            tdi_d   = cmd_tdi;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_OAC: begin
        tmsc_out = 1'b1;
        tmsc_oen = 1'b1;
        if (fall) begin
          if (cnt_q == 3'd0) begin
            state_d = ST_JSCAN;
            cnt_d   = JS_LAST;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ST_JSCAN: begin
        tmsc_out = op_q[bit_idx];
        tmsc_oen = 1'b1;
        if (fall) begin
          if (cnt_q == 3'd0) begin
            state_d = ST_IDLE;
            if (op_q == JS_OSCAN_ON || op_q == JS_SF_SELECT) oscan_d = 1'b1;
            else if (op_q == JS_OSCAN_OFF)                   oscan_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ST_SF0_DATA: begin
        tmsc_out = hi_q ? tdi_q : tms_q;
        tmsc_oen = 1'b1;
        if (fall) begin
          state_d = ST_SF0_TDO;
          if (tdi_q) begin
            ones_d = ones_inc;
            if (ones_inc == 3'(STUFF_ONES)) state_d = ST_STUFF;
          end else begin
            ones_d = 3'd0;
          end
        end
      end
      ST_STUFF: begin
        tmsc_oen = 1'b1;
        if (fall) begin
          state_d = ST_SF0_TDO;
          ones_d  = 3'd0;
        end
      end
      ST_SF0_TDO: begin
        // TDO is captured on the last high-half cycle, after the 2-flop synchroniser.
        if (fall) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_tdo_d   = sync_q[1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      op_q        <= 4'd0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
      ones_q      <= 3'd0;
      oscan_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= 1'b0;
      err_q       <= 1'b0;
      hi_q        <= 1'b0;
      rdy_q       <= 1'b0;
      sync_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ones_q      <= ones_d;
      oscan_q     <= oscan_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tdo_q   <= rsp_tdo_d;
      err_q       <= err_d;
      hi_q        <= hi_d;
      rdy_q       <= 1'b1;
      sync_q      <= {sync_q[0], tmsc_in};
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tdo   = rsp_tdo_q;
  assign oscan_on  = oscan_q;
  assign cmd_err   = err_q;

endmodule
